// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//
// Upstream timebase for the PWM datapath. A prescaler divides the clock into
// count steps. A WIDTH-bit counter runs 0..period_q on those steps and drives
// comparator input A. A double-buffered duty value drives comparator input B.
// The comparator's A_less_B result comes back in and is registered into a
// glitch-free PWM output.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        run/hold control; holding freezes prescaler and counter
//   prescale      extra clocks per count step (0 = step every clock)
//   load          one-cycle write strobe into the shadow registers
//   period_in     terminal count written by load (counter runs 0..period)
//   duty_in       duty value written by load
//   cmp_a_less_b  comparator result for A=cnt_out, B=duty_out
//   cnt_out       active counter value (comparator A)
//   duty_out      active duty value (comparator B)
//   pwm_out       registered PWM output
//   period_tick   one-clock pulse in the clock after a counter wrap
//   pending       shadow values are waiting for the next wrap
//
// Write interface: load has no ready. Every cycle with load=1 is accepted
// and overwrites the shadow registers, so the last write wins. If the same
// cycle is a wrap step, the written values go live at that wrap and pending
// stays clear.
// -----------------------------------------------------------------------------
module pwm_timebase #(
   parameter int WIDTH = 4,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [PRE_W-1:0] prescale,
   input  logic             load,
   input  logic [WIDTH-1:0] period_in,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             cmp_a_less_b,
   output logic [WIDTH-1:0] cnt_out,
   output logic [WIDTH-1:0] duty_out,
   output logic             pwm_out,
   output logic             period_tick,
   output logic             pending
);

   logic [PRE_W-1:0] pre_cnt;
   logic [WIDTH-1:0] period_q;
   logic [WIDTH-1:0] shadow_period;
   logic [WIDTH-1:0] shadow_duty;
   logic             step;
   logic             wrap;

   // prescale is compared live. If it drops below pre_cnt, pre_cnt keeps
   // counting, wraps through zero and then matches.
   assign step = enable && (pre_cnt == prescale);
   assign wrap = step && (cnt_out == period_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt       <= '0;
         cnt_out       <= '0;
         duty_out      <= '0;
         period_q      <= '1;
         shadow_period <= '1;
         shadow_duty   <= '0;
         pwm_out       <= 1'b0;
         period_tick   <= 1'b0;
         pending       <= 1'b0;
      end else begin
         if (enable) begin
            if (step) pre_cnt <= '0;
            else      pre_cnt <= pre_cnt + 1'b1;
         end

         if (step) begin
            if (wrap) cnt_out <= '0;
            else      cnt_out <= cnt_out + 1'b1;
         end

         // wrap already requires enable, so a held timebase never ticks.
         period_tick <= wrap;

         if (load) begin
            shadow_period <= period_in;
            shadow_duty   <= duty_in;
         end

         // Active values only move at a wrap, so the comparator never sees
         // a mid-period change. A coincident load bypasses the shadow.
         if (wrap && load) begin
            period_q <= period_in;
            duty_out <= duty_in;
         end else if (wrap && pending) begin
            period_q <= shadow_period;
            duty_out <= shadow_duty;
         end

         if (wrap)      pending <= 1'b0;
         else if (load) pending <= 1'b1;

         pwm_out <= cmp_a_less_b & enable;
      end
   end

endmodule

// File: tb/tb_pwm_timebase.sv
module tb_pwm_timebase;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] prescale = '0;
   logic       load = 1'b0;
   logic [3:0] period_in = '0;
   logic [3:0] duty_in = '0;
   logic       cmp_a_less_b;
   logic [3:0] cnt_out;
   logic [3:0] duty_out;
   logic       pwm_out;
   logic       period_tick;
   logic       pending;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pwm_timebase #(.WIDTH(4), .PRE_W(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .prescale(prescale),
      .load(load), .period_in(period_in), .duty_in(duty_in),
      .cmp_a_less_b(cmp_a_less_b), .cnt_out(cnt_out), .duty_out(duty_out),
      .pwm_out(pwm_out), .period_tick(period_tick), .pending(pending)
   );

   // Stand-in for the downstream compare_4 block.
   assign cmp_a_less_b = (cnt_out < duty_out);

   // Reference model: the period is a modulo (period+1) count, and the
   // shadow pair is whatever was written last. That pair goes live at
   // any wrap that has a write outstanding.
   int   m_pre, m_cnt, m_per, m_duty, m_sper, m_sduty;
   logic m_pend, m_tick, m_pwm;

   always @(posedge clk) begin
      int  nsper, nsduty;
      bit  stp, wr;
      if (reset) begin
         m_pre <= 0; m_cnt <= 0; m_per <= 15; m_duty <= 0;
         m_sper <= 15; m_sduty <= 0;
         m_pend <= 0; m_tick <= 0; m_pwm <= 0;
      end else begin
         stp    = enable && (m_pre == int'(prescale));
         wr     = stp && ((m_cnt + 1) % (m_per + 1) == 0);
         nsper  = load ? int'(period_in) : m_sper;
         nsduty = load ? int'(duty_in) : m_sduty;
         m_pwm  <= enable && (m_cnt < m_duty);
         m_tick <= wr;
         if (enable) m_pre <= stp ? 0 : (m_pre + 1) % 256;
         if (stp) m_cnt <= (m_cnt + 1) % (m_per + 1);
         m_sper  <= nsper;
         m_sduty <= nsduty;
         if (wr && (m_pend || load)) begin
            m_per  <= nsper;
            m_duty <= nsduty;
         end
         m_pend <= !wr && (m_pend || load);
      end
   end

   wire [10:0] obs  = {cnt_out, duty_out, pwm_out, period_tick, pending};
   wire [10:0] expv = {m_cnt[3:0], m_duty[3:0], m_pwm, m_tick, m_pend};

   // Runs from one period_tick to the next and reports the window length,
   // the number of pwm-high clocks, and any model disagreement seen on
   // the way. The caller judges the numbers.
   task automatic measure(output int len, output int highs, output int mm,
                          output bit to);
      int n = 0;
      len = 0; highs = 0; mm = 0; to = 0;
      while (period_tick !== 1'b1 && n < 600) begin
         @(negedge clk); n++;
         if (obs !== expv) mm++;
      end
      if (n >= 600) begin to = 1; return; end
      do begin
         highs += int'(pwm_out);
         @(negedge clk); len++;
         if (obs !== expv) mm++;
      end while (period_tick !== 1'b1 && len < 600);
      if (len >= 600) to = 1;
   endtask

   task automatic wait_model(input int cnt_val, input bit at_wrap, output bit to);
      int n = 0;
      to = 0;
      while (n < 600) begin
         if (at_wrap ? (m_cnt == m_per && m_pre == int'(prescale)) : (m_cnt == cnt_val))
            return;
         @(negedge clk); n++;
      end
      to = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; load = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (obs !== 11'd0) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", obs, 11'd0);
      end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      int len, highs, mm; bit to;
      enable = 1'b1; prescale = 8'd0;
      @(negedge clk);
      total++;
      if (cnt_out !== 4'd1) begin
         bad++; $display("FAIL first_step got=%0d exp=1", cnt_out);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL free_run_vec got=%h exp=%h", obs, expv);
         end
      end
      measure(len, highs, mm, to);
      total++;
      if (to || len != 16 || highs != 0 || mm != 0) begin
         bad++; $display("FAIL free_run_period got len=%0d high=%0d mm=%0d to=%0d exp len=16 high=0", len, highs, mm, to);
      end
   endtask

   task automatic test_shadow_load();
      int len, highs, mm; bit to;
      wait_model(5, 0, to);
      load = 1'b1; period_in = 4'd9; duty_in = 4'd3;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (to || pending !== 1'b1 || duty_out !== 4'd0) begin
         bad++; $display("FAIL shadow_pending got pend=%b duty=%0d exp pend=1 duty=0", pending, duty_out);
      end
      measure(len, highs, mm, to);
      total++;
      if (to || duty_out !== 4'd3 || pending !== 1'b0 || len != 10 || highs != 3 || mm != 0) begin
         bad++; $display("FAIL shadow_apply got duty=%0d pend=%b len=%0d high=%0d mm=%0d exp duty=3 pend=0 len=10 high=3", duty_out, pending, len, highs, mm);
      end
      measure(len, highs, mm, to);
      total++;
      if (to || len != 10 || highs != 3 || mm != 0) begin
         bad++; $display("FAIL shadow_period2 got len=%0d high=%0d mm=%0d exp len=10 high=3", len, highs, mm);
      end
   endtask

   task automatic test_prescale();
      int len, highs, mm; bit to;
      prescale = 8'd2;
      load = 1'b1; period_in = 4'd4; duty_in = 4'd2;
      @(negedge clk);
      load = 1'b0;
      measure(len, highs, mm, to);
      measure(len, highs, mm, to);
      total++;
      if (to || len != 15 || highs != 6 || mm != 0) begin
         bad++; $display("FAIL prescale_period got len=%0d high=%0d mm=%0d exp len=15 high=6", len, highs, mm);
      end
   endtask

   task automatic test_wrap_load();
      int len, highs, mm, pend_seen; bit to;
      wait_model(0, 0, to);
      while (m_pre != 0) @(negedge clk);
      prescale = 8'd0;
      wait_model(0, 1, to);
      load = 1'b1; period_in = 4'd5; duty_in = 4'd5;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (to || pending !== 1'b0 || duty_out !== 4'd5 || period_tick !== 1'b1) begin
         bad++; $display("FAIL wrap_load_bypass got pend=%b duty=%0d tick=%b exp pend=0 duty=5 tick=1", pending, duty_out, period_tick);
      end
      pend_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         pend_seen += int'(pending);
      end
      total++;
      if (pend_seen != 0) begin
         bad++; $display("FAIL wrap_load_pending got=%0d exp=0", pend_seen);
      end
      measure(len, highs, mm, to);
      total++;
      if (to || len != 6 || highs != 5 || mm != 0) begin
         bad++; $display("FAIL wrap_load_period got len=%0d high=%0d mm=%0d exp len=6 high=5", len, highs, mm);
      end
   endtask

   task automatic test_hold();
      int len, highs, mm; bit to;
      load = 1'b1; period_in = 4'd15; duty_in = 4'd8;
      @(negedge clk);
      load = 1'b0;
      measure(len, highs, mm, to);
      measure(len, highs, mm, to);
      total++;
      if (to || len != 16 || highs != 8 || mm != 0) begin
         bad++; $display("FAIL hold_setup got len=%0d high=%0d mm=%0d exp len=16 high=8", len, highs, mm);
      end
      wait_model(7, 0, to);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (to || cnt_out !== 4'd7 || pwm_out !== 1'b0 || period_tick !== 1'b0) begin
            bad++; $display("FAIL hold_cycle got cnt=%0d pwm=%b tick=%b exp cnt=7 pwm=0 tick=0", cnt_out, pwm_out, period_tick);
         end
      end
      enable = 1'b1;
      @(negedge clk);
      total++;
      if (cnt_out !== 4'd8 || obs !== expv) begin
         bad++; $display("FAIL hold_resume got cnt=%0d exp=8", cnt_out);
      end
   endtask

   task automatic test_reset_mid();
      int len, highs, mm; bit to;
      wait_model(3, 0, to);
      load = 1'b1; period_in = 4'd3; duty_in = 4'd1;
      @(negedge clk);
      load = 1'b0;
      wait_model(6, 0, to);
      total++;
      if (to || pending !== 1'b1) begin
         bad++; $display("FAIL reset_mid_pending got=%b exp=1", pending);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (obs !== 11'd0) begin
         bad++; $display("FAIL reset_mid_state got=%h exp=%h", obs, 11'd0);
      end
      measure(len, highs, mm, to);
      measure(len, highs, mm, to);
      total++;
      if (to || len != 16 || highs != 0 || mm != 0) begin
         bad++; $display("FAIL reset_mid_period got len=%0d high=%0d mm=%0d exp len=16 high=0", len, highs, mm);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         enable    = ($urandom_range(0, 9) != 0);
         load      = ($urandom_range(0, 7) == 0);
         period_in = 4'($urandom_range(0, 15));
         duty_in   = 4'($urandom_range(0, 15));
         reset     = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) prescale = 8'($urandom_range(0, 3));
         @(negedge clk);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", i, obs, expv);
         end
      end
      load = 1'b0; reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_shadow_load();
      test_prescale();
      test_wrap_load();
      test_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_timebase.md
Name: pwm_timebase

Overview:
- Upstream timebase for the PWM datapath.
- Generates the prescaled 4-bit period counter and the double-buffered duty value that drive the compare_4 A and B inputs.
- Takes the comparator's A_less_B result back in and registers it as the glitch-free PWM output.
- Provides a period-boundary tick, and a pending flag for software writes from the MIPS bus.

Parameters:
- WIDTH, 4, width of counter, period and duty; must match the comparator width.
- PRE_W, 8, width of the prescaler counter and the prescale input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run/hold control for the timebase.
- prescale  in  PRE_W  number of extra clocks per count step; 0 means step every clock.
- load  in  1  one-cycle write strobe; captures period_in and duty_in into the shadow registers.
- period_in  in  WIDTH  terminal count value; counter runs 0..period.
- duty_in  in  WIDTH  duty value to compare against the counter.
- cmp_a_less_b  in  1  A_less_B from the downstream comparator (A=cnt_out, B=duty_out).
- cnt_out  out  WIDTH  active counter value, wired to comparator A.
- duty_out  out  WIDTH  active duty value, wired to comparator B.
- pwm_out  out  1  registered PWM output.
- period_tick  out  1  one-clock pulse on counter wrap.
- pending  out  1  high while a shadow update awaits the next wrap.

Behaviour:
- Reset (synchronous, highest priority):
  - pre_cnt=0, cnt_out=0, duty_out=0, period_q=all ones (15).
  - Shadow period=15, shadow duty=0.
  - pwm_out=0, period_tick=0, pending=0.
- Prescaler, when enable=1:
  - If pre_cnt==prescale: pre_cnt<=0 and step=1 for that cycle.
  - Otherwise pre_cnt<=pre_cnt+1.
  - Each step therefore occurs every prescale+1 clocks.
  - A prescale change mid-count is compared live. If pre_cnt>prescale, pre_cnt continues counting up, wraps modulo 2^PRE_W, and then matches.
- Counter, on step:
  - If cnt_out==period_q: cnt_out<=0 (wrap).
  - Otherwise cnt_out<=cnt_out+1.
  - period_q=0 gives a counter held at 0 with a wrap on every step.
- period_tick is registered: 1 in the clock after a wrap step, otherwise 0.
- Shadow update:
  - load=1 writes period_in and duty_in into the shadow registers and sets pending<=1.
  - Back-to-back loads: the last write wins.
- Active update:
  - On a wrap step with pending=1 (or load=1 in the same cycle): period_q and duty_out take the shadow values, and pending<=0.
  - load coincident with a wrap step: the newly loaded values bypass into period_q/duty_out at that wrap, and pending ends 0.
  - Active values never change except at a wrap or reset, so no mid-period glitch.
- pwm_out:
  - pwm_out<=cmp_a_less_b & enable.
  - One clock of latency from cnt_out/duty_out changes, plus the comparator path.
  - Duty 0 gives a constant 0. Duty greater than period gives a constant 1.
  - High time per period = duty steps; period = (period_q+1) steps.
- enable=0:
  - pre_cnt and cnt_out hold, and period_tick=0.
  - pwm_out<=0 on the next clock.
  - load is still accepted; pending stays set until a wrap occurs after re-enable.
- Reset mid-period aborts immediately: outputs return to reset values the next clock, and the shadow contents are lost.
- Arithmetic is unsigned, modulo 2^WIDTH and 2^PRE_W. No other overflow is possible, since cnt_out is bounded by period_q.

Test Plan:
1. reset=1 for 2 clocks, then enable=1, prescale=0, no load -> cnt_out steps 0..15 every clock; period_tick pulses every 16 clocks; pwm_out stays 0 (duty 0).
2. load with period_in=9, duty_in=3 mid-period -> pending=1 until the next wrap, then period_q=9, duty_out=3. Each subsequent 10-clock period shows pwm_out high 3 clocks, delayed 1 clock from cnt_out.
3. prescale=2, period=4, duty=2 -> counter steps every 3 clocks; period_tick every 15 clocks; pwm_out high 6 of 15 clocks.
4. load with period_in=5, duty_in=5, asserted exactly on a wrap step -> new values active immediately after the wrap; pending never observed high; pwm_out high 5 of 6 steps.
5. enable dropped at cnt_out=7 for 10 clocks -> cnt_out holds 7, pwm_out=0 after 1 clock, no period_tick. On re-enable, counting resumes at 8.
6. reset asserted with pending=1 and cnt_out=6 -> next clock all outputs at reset values, pending=0, period_q=15.
